// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one framebuffer RAM port between scanout (priority) and round-robin draw clients.
// Optional build macro FB_ARB_TRANSKEY_EN: draw writes of TRANS_KEY are accepted but never reach the RAM.
module fb_port_arbiter #(
    parameter int                NUM_REQ      = 4,
    parameter int                ADDR_W       = 19,
    parameter int                DATA_W       = 24,
    parameter int                STARVE_LIMIT = 16,
    parameter logic [DATA_W-1:0] TRANS_KEY    = 24'hFF00FF
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      scan_req,
    input  logic [ADDR_W-1:0]         scan_addr,
    output logic                      scan_ready,
    output logic                      scan_rvalid,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic [1:0]                dbg_state
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAW = 2'd2, FORCE = 2'd3} state_t;

    // Handshake: a transfer happens in a cycle where both valid and ready are high;
    // requesters hold addr/we/wdata stable until they see ready.
    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [7:0]         starve_cnt;
    logic [PTR_W-1:0]   sel;
    logic               draw_found;
    logic               grant_scan, grant_draw;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               key_hit;
    logic               tag_scan;
    logic [NUM_REQ-1:0] tag_rsp;
    int                 idx;

    always_comb begin
        draw_found = 1'b0;
        sel        = '0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!draw_found && req_valid[idx]) begin
                draw_found = 1'b1;
                sel        = PTR_W'(idx);
            end
        end
    end

    // A draw grant while scan_req is high can only be the starvation override.
    always_comb begin
        grant_scan = 1'b0;
        grant_draw = 1'b0;
        state_next = IDLE;
        if (!Reset) begin
            if (scan_req && (starve_cnt < 8'(STARVE_LIMIT))) begin
                grant_scan = 1'b1;
                state_next = SCAN;
            end else if (draw_found) begin
                grant_draw = 1'b1;
                state_next = scan_req ? FORCE : DRAW;
            end
        end
    end

    assign sel_we    = req_we[sel];
    assign sel_addr  = req_addr[sel*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[sel*DATA_W +: DATA_W];

`ifdef FB_ARB_TRANSKEY_EN
    assign key_hit = (sel_wdata == TRANS_KEY);
`else
    assign key_hit = 1'b0 & (sel_wdata == TRANS_KEY);
`endif

    always_comb begin
        scan_ready = grant_scan;
        req_ready  = '0;
        ram_we     = 1'b0;
        ram_addr   = scan_addr;
        ram_wdata  = '0;
        if (grant_draw) begin
            req_ready[sel] = 1'b1;
            ram_addr       = sel_addr;
            ram_wdata      = sel_wdata;
            ram_we         = sel_we && !key_hit;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
            tag_scan   <= 1'b0;
            tag_rsp    <= '0;
        end else begin
            tag_scan <= grant_scan;
            tag_rsp  <= (grant_draw && !sel_we) ? req_ready : '0;
            if (grant_draw)
                rr_ptr <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            if (grant_draw || (req_valid == '0))
                starve_cnt <= '0;
            else if (grant_scan)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Responses are masked while Reset is high so a read caught in flight is dropped.
    assign scan_rvalid = tag_scan && !Reset;
    assign rsp_valid   = Reset ? '0 : tag_rsp;
    assign rd_data     = (scan_rvalid || (rsp_valid != '0)) ? ram_rdata : '0;
    assign dbg_state   = state;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed stimulus, a per-cycle behavioural model of the arbitration rules,
// a 1-cycle RAM model and literal expectations for the key scenarios.
module tb_fb_port_arbiter;
    localparam int                NUM_REQ      = 4;
    localparam int                ADDR_W       = 19;
    localparam int                DATA_W       = 24;
    localparam int                STARVE_LIMIT = 16;
    localparam logic [DATA_W-1:0] TRANS_KEY    = 24'hFF00FF;
    localparam int                RSP_W        = 1 + NUM_REQ + DATA_W;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      scan_req;
    logic [ADDR_W-1:0]         scan_addr;
    logic                      scan_ready, scan_rvalid;
    logic [NUM_REQ-1:0]        req_valid, req_we, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         rd_data, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0]         ram_addr;
    logic                      ram_we;
    logic [1:0]                dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram_arr [int];
    logic [DATA_W-1:0] m_mem [int];
    logic [RSP_W-1:0]  exp_q [$];
    int                m_ptr = 0;
    int                m_cnt = 0;
    logic [1:0]        m_state = 2'd0;

    fb_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .TRANS_KEY(TRANS_KEY)
    ) dut (
        .Clk(clk), .Reset(reset),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_ready(scan_ready), .scan_rvalid(scan_rvalid),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM: registered read of the current address, write on ram_we.
    always @(posedge clk) begin
        ram_rdata <= ram_arr.exists(int'(ram_addr)) ? ram_arr[int'(ram_addr)] : '0;
        if (ram_we) ram_arr[int'(ram_addr)] = ram_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic v, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i] = v;
        req_we[i] = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Model: g = -1 no grant, NUM_REQ scan, 0..NUM_REQ-1 draw client.
    always @(negedge clk) begin
        int                g;
        int                c;
        int                ekey;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata, rdv;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [RSP_W-1:0]  due, nxt;
        g = -1;
        if (!reset) begin
            if (scan_req && m_cnt < STARVE_LIMIT) g = NUM_REQ;
            else
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
        end
        exp_rdy = '0;
        exp_we = 1'b0;
        exp_addr = scan_addr;
        exp_wdata = '0;
        if (g >= 0 && g < NUM_REQ) begin
            exp_rdy[g] = 1'b1;
            exp_addr = req_addr[g*ADDR_W +: ADDR_W];
            exp_wdata = req_wdata[g*DATA_W +: DATA_W];
            exp_we = req_we[g];
`ifdef FB_ARB_TRANSKEY_EN
            if (exp_wdata == TRANS_KEY) exp_we = 1'b0;
`endif
        end
        check("m_scan_ready", scan_ready, g == NUM_REQ);
        check("m_req_ready", req_ready, exp_rdy);
        check("m_ram_we", ram_we, exp_we);
        check("m_ram_addr", ram_addr, exp_addr);
        if (exp_we) check("m_ram_wdata", ram_wdata, exp_wdata);
        due = exp_q.pop_front();
        if (reset) due = '0;
        check("m_scan_rvalid", scan_rvalid, due[RSP_W-1]);
        check("m_rsp_valid", rsp_valid, due[DATA_W +: NUM_REQ]);
        if (due[RSP_W-1] || due[DATA_W +: NUM_REQ] != '0) check("m_rd_data", rd_data, due[DATA_W-1:0]);
        if (!reset) check("m_state", dbg_state, m_state);

        ekey = int'(exp_addr);
        rdv = m_mem.exists(ekey) ? m_mem[ekey] : '0;
        nxt = '0;
        if (g == NUM_REQ) begin
            nxt[RSP_W-1] = 1'b1;
            nxt[DATA_W-1:0] = rdv;
        end else if (g >= 0 && !req_we[g]) begin
            nxt[DATA_W + g] = 1'b1;
            nxt[DATA_W-1:0] = rdv;
        end
        exp_q.push_back(nxt);
        if (exp_we) m_mem[ekey] = exp_wdata;

        if (reset) begin
            m_ptr = 0;
            m_cnt = 0;
            m_state = 2'd0;
        end else begin
            if (g < 0) m_state = 2'd0;
            else if (g == NUM_REQ) m_state = 2'd1;
            else m_state = scan_req ? 2'd3 : 2'd2;
            if (g >= 0 && g < NUM_REQ) m_ptr = (g + 1) % NUM_REQ;
            if ((g >= 0 && g < NUM_REQ) || req_valid == '0) m_cnt = 0;
            else if (g == NUM_REQ) m_cnt = m_cnt + 1;
        end
    end

    initial begin
        int                rr_client [6];
        logic [NUM_REQ-1:0] rr_onehot [6];
        rr_client = '{0, 2, 3, 0, 2, 3};
        rr_onehot = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        exp_q.push_back('0);
        ram_arr[1234] = 24'h123456;
        m_mem[1234] = 24'h123456;

        reset = 1'b1;
        scan_req = 1'b1;
        scan_addr = 19'd7;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) set_client(i, 1'b1, 1'b1, 19'(100 + i), 24'hA00000 + 24'(i));

        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            check("rst_ram_we", ram_we, 1'b0);
            check("rst_ready", {scan_ready, req_ready}, '0);
            check("rst_rvalid", {scan_rvalid, rsp_valid}, '0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("first_grant_scan", scan_ready, 1'b1);

        tick();
        scan_req = 1'b0;
        req_valid = 4'b1101;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("rr_grant", req_ready, rr_onehot[n]);
            check("rr_addr", ram_addr, 19'(100 + rr_client[n]));
            check("rr_wdata", ram_wdata, 24'hA00000 + 24'(rr_client[n]));
            tick();
        end

        req_valid = '0;
        set_client(1, 1'b1, 1'b0, 19'd1234, 24'h0);
        @(negedge clk);
        check("rd_ready", req_ready, 4'b0010);
        check("rd_we", ram_we, 1'b0);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 4'b0010);
        check("rd_data", rd_data, 24'h123456);

        tick();
        scan_req = 1'b1;
        scan_addr = 19'd5;
        set_client(0, 1'b1, 1'b1, 19'd200, 24'h00BEEF);
        for (int n = 0; n < 34; n++) begin
            @(negedge clk);
            check("starve_scan_ready", scan_ready, (n % 17) != 16);
            check("starve_draw_ready", req_ready[0], (n % 17) == 16);
            tick();
        end

        req_valid = '0;
        set_client(2, 1'b1, 1'b1, 19'd300, 24'h111111);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("skip_no_ready", req_ready, 4'b0000);
            tick();
        end
        req_valid = '0;

        scan_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_client(i, 1'b1, 1'b0, 19'(100 + i), 24'h0);
        repeat (8) tick();
        req_valid = '0;

        scan_req = 1'b1;
        scan_addr = 19'd100;
        @(negedge clk);
        check("inflight_issue", scan_ready, 1'b1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("inflight_dropped", scan_rvalid, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("scan_issue", scan_ready, 1'b1);
        tick();
        scan_addr = 19'd102;
        @(negedge clk);
        check("scan_rvalid_0", scan_rvalid, 1'b1);
        check("scan_rdata_0", rd_data, 24'hA00000);
        tick();
        scan_req = 1'b0;
        @(negedge clk);
        check("scan_rvalid_1", scan_rvalid, 1'b1);
        check("scan_rdata_1", rd_data, 24'hA00002);

`ifdef FB_ARB_TRANSKEY_EN
        tick();
        set_client(0, 1'b1, 1'b1, 19'd400, 24'hFF00FF);
        @(negedge clk);
        check("key_ready", req_ready[0], 1'b1);
        check("key_no_we", ram_we, 1'b0);
        tick();
        set_client(0, 1'b1, 1'b1, 19'd400, 24'hFF00FE);
        @(negedge clk);
        check("nonkey_we", ram_we, 1'b1);
`endif

        tick();
        req_valid = '0;
        scan_req = 1'b0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
